// File: rtl/dac_spi_pkg.sv
// Shared definitions for the DAC SPI link: command codes, address
// encodings and the bit layout of the 32-bit LTC2624-style frame.
// Consumers: dac_spi_responder, the DacSpi master, cntr.
package dac_spi_pkg;

    localparam int unsigned FRAME_BITS = 32;
    localparam int unsigned DATA_W     = 12;
    localparam int unsigned CNT_W      = 6;

    // Frame field positions (bits 31..24 and 3..0 are don't care)
    localparam int unsigned CMD_MSB  = 23;
    localparam int unsigned CMD_LSB  = 20;
    localparam int unsigned ADDR_MSB = 19;
    localparam int unsigned ADDR_LSB = 16;
    localparam int unsigned DATA_MSB = 15;
    localparam int unsigned DATA_LSB = 4;

    localparam logic [3:0] CMD_WRITE_N       = 4'h0;
    localparam logic [3:0] CMD_UPDATE_N      = 4'h1;
    localparam logic [3:0] CMD_WRITE_UPD_ALL = 4'h2;
    localparam logic [3:0] CMD_WRITE_UPD_N   = 4'h3;
    localparam logic [3:0] CMD_PWRDN_N       = 4'h4;
    localparam logic [3:0] CMD_NOP           = 4'hF;

    localparam logic [3:0] ADDR_ALL = 4'hF;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } frame_state_e;

endpackage

// File: rtl/dac_spi_responder_if.sv
// DAC SPI wire bundle.
//   master: drives SPI_SCK, DAC_CS (active low), SPI_MOSI, DAC_CLR (active low)
//   slave : drives DAC_OUT (echo of the previous frame)
interface dac_spi_responder_if;
    logic SPI_SCK;
    logic DAC_CS;
    logic SPI_MOSI;
    logic DAC_CLR;
    logic DAC_OUT;

    modport master (output SPI_SCK, output DAC_CS, output SPI_MOSI,
                    output DAC_CLR, input DAC_OUT);
    modport slave  (input SPI_SCK, input DAC_CS, input SPI_MOSI,
                    input DAC_CLR, output DAC_OUT);
endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer with single-cycle rise/fall pulses.
//   clk_i, rst_i : clock, synchronous active-high reset
//   d_i          : asynchronous input
//   q_o          : synchronized level (registered)
//   rise_c_o     : one-cycle pulse on synchronized 0->1
//   fall_c_o     : one-cycle pulse on synchronized 1->0
// Reset value is 0 so that an input already low at reset release (e.g. CS
// held low across a reset) never produces a spurious falling edge.
module spi_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o,
    output logic rise_c_o,
    output logic fall_c_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   dly_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
            dly_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
            dly_q  <= sync_q[SYNC_STAGES-1];
        end
    end

    assign q_o      = sync_q[SYNC_STAGES-1];
    assign rise_c_o =  sync_q[SYNC_STAGES-1] & ~dly_q;
    assign fall_c_o = ~sync_q[SYNC_STAGES-1] &  dly_q;

endmodule

// File: rtl/dac_spi_responder.sv
// DAC-side responder for the DAC SPI link. Oversamples the SPI wires on
// CLK50MHZ, decodes 32-bit frames into 4 input/dac registers, and echoes
// the previously accepted frame on DAC_OUT.
//   CLK50MHZ, RST : clock, synchronous active-high reset
//   spi           : SPI wire bundle (slave side)
//   dac_value     : channel outputs, ch n at [12n+11:12n]
//   power_down    : per-channel power-down flags
//   frame_valid   : 1-cycle pulse on accepted frame
//   frame_cmd/addr: fields of the last accepted frame
//   frame_err     : 1-cycle pulse on short frame
// Optional: DAC_SPI_RESPONDER_FRAMECHK_EN enables frame_err and the
// saturating err_cnt counter; otherwise frame_err is tied 0.
module dac_spi_responder
    import dac_spi_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned NCH         = 4
) (
    input  logic                    CLK50MHZ,
    input  logic                    RST,
    dac_spi_responder_if.slave      spi,
    output logic [NCH*DATA_W-1:0]   dac_value,
    output logic [NCH-1:0]          power_down,
    output logic                    frame_valid,
    output logic [3:0]              frame_cmd,
    output logic [3:0]              frame_addr,
    output logic                    frame_err
);

    logic sck_rise, sck_fall, sck_lvl_unused;
    logic cs_rise, cs_fall, cs_lvl_unused;
    logic mosi_s, mosi_rise_unused, mosi_fall_unused;
    logic clr_s, clr_rise_unused, clr_fall_unused;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sck (
        .clk_i(CLK50MHZ), .rst_i(RST), .d_i(spi.SPI_SCK),
        .q_o(sck_lvl_unused), .rise_c_o(sck_rise), .fall_c_o(sck_fall));
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
        .clk_i(CLK50MHZ), .rst_i(RST), .d_i(spi.DAC_CS),
        .q_o(cs_lvl_unused), .rise_c_o(cs_rise), .fall_c_o(cs_fall));
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
        .clk_i(CLK50MHZ), .rst_i(RST), .d_i(spi.SPI_MOSI),
        .q_o(mosi_s), .rise_c_o(mosi_rise_unused), .fall_c_o(mosi_fall_unused));
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clr (
        .clk_i(CLK50MHZ), .rst_i(RST), .d_i(spi.DAC_CLR),
        .q_o(clr_s), .rise_c_o(clr_rise_unused), .fall_c_o(clr_fall_unused));

    frame_state_e                     state_q, state_d;
    logic [FRAME_BITS-1:0]            rx_shift_q, rx_shift_d;
    logic [FRAME_BITS-1:0]            tx_shift_q, tx_shift_d;
    logic [FRAME_BITS-1:0]            last_word_q, last_word_d;
    logic [CNT_W-1:0]                 bit_cnt_q, bit_cnt_d;
    logic [NCH-1:0][DATA_W-1:0]       in_q, in_d;
    logic [NCH-1:0][DATA_W-1:0]       dac_q, dac_d;
    logic [NCH-1:0]                   pd_q, pd_d;
    logic [3:0]                       cmd_q, cmd_d, addr_q, addr_d;
    logic                             valid_q, valid_d;
    logic                             dac_out_q, dac_out_d;

    logic [3:0]                       rx_cmd, rx_addr;
    logic [DATA_W-1:0]                rx_data;
    logic                             frame_end_c, frame_full_c, accept_c;
    logic [NCH-1:0]                   sel_c;

    assign rx_cmd  = rx_shift_q[CMD_MSB:CMD_LSB];
    assign rx_addr = rx_shift_q[ADDR_MSB:ADDR_LSB];
    assign rx_data = rx_shift_q[DATA_MSB:DATA_LSB];

    // Frame ends on CS rise while shifting; full only with 32+ bits clocked in
    assign frame_end_c  = (state_q == ST_SHIFT) && cs_rise;
    assign frame_full_c = (bit_cnt_q == CNT_W'(FRAME_BITS));
    assign accept_c     = frame_end_c && frame_full_c;

    // Channel select: one channel, all channels, or none for other addresses
    always_comb begin
        sel_c = '0;
        for (int unsigned ch = 0; ch < NCH; ch++) begin
            sel_c[ch] = (rx_addr == ADDR_ALL) || (rx_addr == 4'(ch));
        end
    end

    // Next-state: frame FSM, shift registers, decode, clear
    always_comb begin
        state_d     = state_q;
        rx_shift_d  = rx_shift_q;
        tx_shift_d  = tx_shift_q;
        last_word_d = last_word_q;
        bit_cnt_d   = bit_cnt_q;
        in_d        = in_q;
        dac_d       = dac_q;
        pd_d        = pd_q;
        cmd_d       = cmd_q;
        addr_d      = addr_q;
        valid_d     = 1'b0;
        dac_out_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d    = ST_SHIFT;
                    bit_cnt_d  = '0;
                    tx_shift_d = last_word_q;
                end
            end
            ST_SHIFT: begin
                if (sck_rise) begin
                    rx_shift_d = {rx_shift_q[FRAME_BITS-2:0], mosi_s};
                    if (!frame_full_c) begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
                if (sck_fall) begin
                    tx_shift_d = {tx_shift_q[FRAME_BITS-2:0], 1'b0};
                end
                if (cs_rise) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (accept_c) begin
            last_word_d = rx_shift_q;
            valid_d     = 1'b1;
            cmd_d       = rx_cmd;
            addr_d      = rx_addr;
            for (int unsigned ch = 0; ch < NCH; ch++) begin
                if (sel_c[ch]) begin
                    unique case (rx_cmd)
                        CMD_WRITE_N, CMD_WRITE_UPD_ALL: in_d[ch] = rx_data;
                        CMD_UPDATE_N: begin
                            dac_d[ch] = in_q[ch];
                            pd_d[ch]  = 1'b0;
                        end
                        CMD_WRITE_UPD_N: begin
                            in_d[ch]  = rx_data;
                            dac_d[ch] = rx_data;
                            pd_d[ch]  = 1'b0;
                        end
                        CMD_PWRDN_N: pd_d[ch] = 1'b1;
                        default: ;
                    endcase
                end
            end
            // Global update uses the freshly written input value
            if (rx_cmd == CMD_WRITE_UPD_ALL && (|sel_c)) begin
                dac_d = in_d;
            end
        end

        // Clear overrides any same-cycle decode; power-down untouched
        if (!clr_s) begin
            in_d  = '0;
            dac_d = '0;
        end

        if (state_d == ST_SHIFT) begin
            dac_out_d = tx_shift_d[FRAME_BITS-1];
        end
    end

    always_ff @(posedge CLK50MHZ) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            rx_shift_q  <= '0;
            tx_shift_q  <= '0;
            last_word_q <= '0;
            bit_cnt_q   <= '0;
            in_q        <= '0;
            dac_q       <= '0;
            pd_q        <= '0;
            cmd_q       <= '0;
            addr_q      <= '0;
            valid_q     <= 1'b0;
            dac_out_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rx_shift_q  <= rx_shift_d;
            tx_shift_q  <= tx_shift_d;
            last_word_q <= last_word_d;
            bit_cnt_q   <= bit_cnt_d;
            in_q        <= in_d;
            dac_q       <= dac_d;
            pd_q        <= pd_d;
            cmd_q       <= cmd_d;
            addr_q      <= addr_d;
            valid_q     <= valid_d;
            dac_out_q   <= dac_out_d;
        end
    end

`ifdef DAC_SPI_RESPONDER_FRAMECHK_EN
    logic             err_q;
    logic [CNT_W-1:0] err_cnt_q;
    logic [CNT_W-1:0] err_cnt;

    // Short-frame pulse and sticky saturating count
    always_ff @(posedge CLK50MHZ) begin
        if (RST) begin
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            err_q <= frame_end_c && !frame_full_c;
            if (frame_end_c && !frame_full_c && (err_cnt_q != '1)) begin
                err_cnt_q <= err_cnt_q + CNT_W'(1);
            end
        end
    end

    assign err_cnt   = err_cnt_q;
    assign frame_err = err_q;
`else
    assign frame_err = 1'b0;
`endif

    assign spi.DAC_OUT = dac_out_q;
    assign dac_value   = dac_q;
    assign power_down  = pd_q;
    assign frame_valid = valid_q;
    assign frame_cmd   = cmd_q;
    assign frame_addr  = addr_q;

endmodule

// File: tb/tb_dac_spi_responder.sv
// Scoreboard bench for dac_spi_responder: each accepted frame pushes the
// expected cmd/addr/dac_value/power_down; the frame_valid monitor pops it.
module tb_dac_spi_responder;

    localparam int HALF = 6;

    typedef struct packed {
        logic [3:0]  cmd;
        logic [3:0]  addr;
        logic [47:0] dac;
        logic [3:0]  pd;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [47:0] dac_value;
    logic [3:0]  power_down;
    logic        frame_valid;
    logic [3:0]  frame_cmd;
    logic [3:0]  frame_addr;
    logic        frame_err;

    dac_spi_responder_if bus_if ();

    dac_spi_responder dut (
        .CLK50MHZ   (clk),
        .RST        (rst),
        .spi        (bus_if),
        .dac_value  (dac_value),
        .power_down (power_down),
        .frame_valid(frame_valid),
        .frame_cmd  (frame_cmd),
        .frame_addr (frame_addr),
        .frame_err  (frame_err)
    );

    always #10 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   err_pulses = 0;
    exp_t sb[$];

    logic [11:0] m_in  [4];
    logic [11:0] m_dac [4];
    logic [3:0]  m_pd;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [47:0] m_flat();
        logic [47:0] f;
        for (int i = 0; i < 4; i++) f[12*i +: 12] = m_dac[i];
        return f;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 4; i++) begin
            m_in[i]  = '0;
            m_dac[i] = '0;
        end
        m_pd = '0;
    endtask

    // Reference behaviour for one accepted 32-bit word
    task automatic m_apply(input logic [31:0] w);
        logic [3:0]  c, a;
        logic [11:0] d;
        exp_t        e;
        c = w[23:20];
        a = w[19:16];
        d = w[15:4];
        for (int i = 0; i < 4; i++) begin
            if (a == 4'hF || a == i[3:0]) begin
                case (c)
                    4'h0: m_in[i] = d;
                    4'h1: begin m_dac[i] = m_in[i]; m_pd[i] = 1'b0; end
                    4'h2: m_in[i] = d;
                    4'h3: begin m_in[i] = d; m_dac[i] = d; m_pd[i] = 1'b0; end
                    4'h4: m_pd[i] = 1'b1;
                    default: ;
                endcase
            end
        end
        if (c == 4'h2 && (a == 4'hF || a < 4'd4)) begin
            for (int i = 0; i < 4; i++) m_dac[i] = m_in[i];
        end
        e.cmd  = c;
        e.addr = a;
        e.dac  = m_flat();
        e.pd   = m_pd;
        sb.push_back(e);
    endtask

    // Drives nbits of w (MSB first); rst_at >= 0 pulses RST before that bit.
    // echo collects DAC_OUT sampled just before each SCK rise.
    task automatic send_frame(input logic [63:0] w, input int nbits, input int rst_at,
                              output logic [31:0] echo);
        echo = '0;
        bus_if.DAC_CS = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = nbits - 1; i >= 0; i--) begin
            if (nbits - 1 - i == rst_at) begin
                rst = 1'b1;
                repeat (3) @(negedge clk);
                rst = 1'b0;
            end
            bus_if.SPI_MOSI = w[i];
            repeat (HALF) @(negedge clk);
            echo = {echo[30:0], bus_if.DAC_OUT};
            bus_if.SPI_SCK = 1'b1;
            repeat (HALF) @(negedge clk);
            bus_if.SPI_SCK = 1'b0;
        end
        repeat (HALF) @(negedge clk);
        bus_if.DAC_CS = 1'b1;
        repeat (2 * HALF) @(negedge clk);
    endtask

    task automatic wait_drain(input string tag);
        for (int k = 0; k < 50 && sb.size() != 0; k++) @(negedge clk);
        chk_eq(tag, 64'(sb.size()), 64'd0);
    endtask

    task automatic send_ok(input logic [63:0] w, input int nbits, output logic [31:0] echo);
        m_apply(w[31:0]);
        send_frame(w, nbits, -1, echo);
        wait_drain("sb_drain");
    endtask

    // Scoreboard consumer on frame_valid
    always @(negedge clk) begin
        if (!rst && frame_valid) begin
            if (sb.size() == 0) begin
                chk_eq("unexpected_frame_valid", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk_eq("frame_cmd",  64'(frame_cmd),  64'(e.cmd));
                chk_eq("frame_addr", 64'(frame_addr), 64'(e.addr));
                chk_eq("dac_value",  64'(dac_value),  64'(e.dac));
                chk_eq("power_down", 64'(power_down), 64'(e.pd));
            end
        end
        if (!rst && frame_err) err_pulses++;
    end

    initial begin
        logic [31:0] echo;
        int          exp_err;
        rst             = 1'b1;
        bus_if.DAC_CS   = 1'b1;
        bus_if.SPI_SCK  = 1'b0;
        bus_if.SPI_MOSI = 1'b0;
        bus_if.DAC_CLR  = 1'b1;
        m_reset();
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);

        chk_eq("rst_dac_value",   64'(dac_value),   64'd0);
        chk_eq("rst_power_down",  64'(power_down),  64'd0);
        chk_eq("rst_frame_valid", 64'(frame_valid), 64'd0);
        chk_eq("rst_frame_cmd",   64'(frame_cmd),   64'd0);
        chk_eq("rst_frame_addr",  64'(frame_addr),  64'd0);
        chk_eq("rst_dac_out",     64'(bus_if.DAC_OUT), 64'd0);

        send_ok(64'h0030ABC0, 32, echo);
        chk_eq("echo_after_reset", 64'(echo), 64'd0);
        send_ok(64'h00021230, 32, echo);
        send_ok(64'h00120000, 32, echo);
        chk_eq("ch2_updated", 64'(dac_value[35:24]), 64'h123);

        send_ok(64'h003F5550, 32, echo);
        send_ok(64'h00430000, 32, echo);
        bus_if.DAC_CLR = 1'b0;
        repeat (10) @(negedge clk);
        bus_if.DAC_CLR = 1'b1;
        repeat (6) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            m_in[i]  = '0;
            m_dac[i] = '0;
        end
        chk_eq("clr_dac_value",  64'(dac_value),  64'd0);
        chk_eq("clr_power_down", 64'(power_down), 64'(4'b1000));

        send_ok(64'h0030ABC0, 32, echo);
        send_ok(64'h00F00000, 32, echo);
        chk_eq("echo_prev_frame", 64'(echo), 64'h0030ABC0);

        send_ok(64'h3_0031_1770, 34, echo);
        chk_eq("extra_bits_ch1", 64'(dac_value[23:12]), 64'h177);
        send_ok(64'h00350000, 32, echo);

        send_frame(64'h12345, 20, -1, echo);
        wait_drain("short_no_valid");
        chk_eq("short_dac_value", 64'(dac_value), 64'(m_flat()));
`ifdef DAC_SPI_RESPONDER_FRAMECHK_EN
        exp_err = 1;
        chk_eq("err_cnt", 64'(dut.err_cnt), 64'd1);
`else
        exp_err = 0;
`endif
        chk_eq("short_err_pulses", 64'(err_pulses), 64'(exp_err));

        send_frame(64'h0030FFF0, 32, 16, echo);
        m_reset();
        repeat (10) @(negedge clk);
        chk_eq("abort_dac_value",  64'(dac_value),  64'd0);
        chk_eq("abort_power_down", 64'(power_down), 64'd0);
        chk_eq("abort_frame_cmd",  64'(frame_cmd),  64'd0);
        chk_eq("abort_dac_out",    64'(bus_if.DAC_OUT), 64'd0);
        chk_eq("abort_no_valid",   64'(sb.size()), 64'd0);
        chk_eq("abort_err_pulses", 64'(err_pulses), 64'(exp_err));

        send_ok(64'h00400000, 32, echo);
        chk_eq("pd_ch0", 64'(power_down), 64'(4'b0001));
        chk_eq("echo_cleared_by_rst", 64'(echo), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
